// File: rtl/aes_encryption_if.sv
// Encryption request/result bus between the key-memory side (master) and
// the AES round engine (slave).
interface aes_encryption_if;
  logic         next;
  logic         keylen;
  logic [3:0]   round;
  logic [127:0] round_key;
  logic [127:0] block;
  logic [127:0] new_block;
  logic         ready;

  modport master (
    output next, keylen, round_key, block,
    input  round, new_block, ready
  );

  modport slave (
    input  next, keylen, round_key, block,
    output round, new_block, ready
  );
endinterface

// File: rtl/aes_encryption.sv
// Iterative AES-128/256 encryption datapath; round keys come from an external key memory.
// Define AES_ENC_PARALLEL_SBOX_EN for four S-box instances and a single-cycle SBOX state.
module aes_sbox (
  input  logic [31:0] word,
  output logic [31:0] sub_word
);
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry 0 sits in the top byte of the table, so byte b lives at offset (255-b)*8.
  function automatic logic [7:0] lookup(input logic [7:0] b);
    return SBOX_TABLE[{~b, 3'b000} +: 8];
  endfunction

  assign sub_word = {lookup(word[31:24]), lookup(word[23:16]),
                     lookup(word[15:8]),  lookup(word[7:0])};
endmodule

module aes_encryption (
  input  logic              clk,
  input  logic              reset_n,
  aes_encryption_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, INIT, SBOX, MAIN} state_t;

  state_t       state;
  logic [31:0]  w0, w1, w2, w3;
  logic [3:0]   cur_round;
  logic         done;
  logic         keylen_q;
  logic [3:0]   last_round;
  logic [127:0] state_vec, sr_vec, mc_vec;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // Byte (row r, column c) is at bit offset 127-8*(4c+r); row r rotates left by r.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + r) % 4) + r) -: 8];
      end
    end
    return o;
  endfunction

  assign state_vec  = {w0, w1, w2, w3};
  assign last_round = keylen_q ? 4'd14 : 4'd10;

  always_comb begin
    sr_vec = shift_rows(state_vec);
    mc_vec = {mix_column(sr_vec[127:96]), mix_column(sr_vec[95:64]),
              mix_column(sr_vec[63:32]),  mix_column(sr_vec[31:0])};
  end

`ifdef AES_ENC_PARALLEL_SBOX_EN
  logic [31:0] sb0, sb1, sb2, sb3;

  aes_sbox u_sbox0 (.word(w0), .sub_word(sb0));
  aes_sbox u_sbox1 (.word(w1), .sub_word(sb1));
  aes_sbox u_sbox2 (.word(w2), .sub_word(sb2));
  aes_sbox u_sbox3 (.word(w3), .sub_word(sb3));
`else
  logic [1:0]  sword;
  logic [31:0] sbox_in, sbox_out;

  always_comb begin
    case (sword)
      2'd0:    sbox_in = w0;
      2'd1:    sbox_in = w1;
      2'd2:    sbox_in = w2;
      default: sbox_in = w3;
    endcase
  end

  aes_sbox u_sbox (.word(sbox_in), .sub_word(sbox_out));
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      done      <= 1'b1;
      cur_round <= '0;
      w0        <= '0;
      w1        <= '0;
      w2        <= '0;
      w3        <= '0;
      keylen_q  <= 1'b0;
`ifndef AES_ENC_PARALLEL_SBOX_EN
      sword     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.next) begin
            cur_round <= '0;
            done      <= 1'b0;
            keylen_q  <= bus.keylen;
            state     <= INIT;
          end
        end
        INIT: begin
          {w0, w1, w2, w3} <= bus.block ^ bus.round_key;
          cur_round        <= 4'd1;
`ifndef AES_ENC_PARALLEL_SBOX_EN
          sword            <= '0;
`endif
          state            <= SBOX;
        end
        SBOX: begin
`ifdef AES_ENC_PARALLEL_SBOX_EN
          {w0, w1, w2, w3} <= {sb0, sb1, sb2, sb3};
          state            <= MAIN;
`else
          case (sword)
            2'd0:    w0 <= sbox_out;
            2'd1:    w1 <= sbox_out;
            2'd2:    w2 <= sbox_out;
            default: w3 <= sbox_out;
          endcase
          sword <= sword + 2'd1;
          if (sword == 2'd3) state <= MAIN;
`endif
        end
        MAIN: begin
          if (cur_round == last_round) begin
            {w0, w1, w2, w3} <= sr_vec ^ bus.round_key;
            done             <= 1'b1;
            state            <= IDLE;
          end else begin
            {w0, w1, w2, w3} <= mc_vec ^ bus.round_key;
            cur_round        <= cur_round + 4'd1;
            state            <= SBOX;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.round     = cur_round;
  assign bus.new_block = state_vec;
  assign bus.ready     = done;
endmodule

// File: tb/tb_aes_encryption.sv
// Scoreboard bench for aes_encryption: byte-level AES reference model, FIPS-197 vectors, random ops.
module tb_aes_encryption;
`ifdef AES_ENC_PARALLEL_SBOX_EN
  localparam int unsigned LAT128 = 21;
  localparam int unsigned LAT256 = 29;
`else
  localparam int unsigned LAT128 = 51;
  localparam int unsigned LAT256 = 71;
`endif
  localparam int unsigned RST_AT = (LAT128 > 30) ? 30 : 15;

  localparam logic [255:0] KEY_C1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  aes_encryption_if bus();
  aes_encryption dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  logic [127:0] rk_mem   [0:15];
  logic [127:0] rk_model [0:15];
  logic [7:0]   sbox_t   [0:255];
  assign bus.round_key = rk_mem[bus.round];

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [127:0] ct; int unsigned due; } exp_t;
  exp_t sbq[$];
  exp_t mon_item;
  int tests = 0;
  int fails = 0;

  // Monitor: each rising edge of ready outside reset must match the oldest expectation.
  logic ready_prev = 1'b1;
  always @(negedge clk) begin
    if (reset_n && bus.ready && !ready_prev) begin
      tests++;
      if (sbq.size() == 0) begin
        fails++;
        $display("FAIL unexpected_result got %h, required no result", bus.new_block);
      end else begin
        mon_item = sbq.pop_front();
        if (bus.new_block !== mon_item.ct) begin
          fails++;
          $display("FAIL ciphertext got %h required %h", bus.new_block, mon_item.ct);
        end
        tests++;
        if (cyc != mon_item.due) begin
          fails++;
          $display("FAIL ready_latency got cycle %0d required %0d", cyc, mon_item.due);
        end
      end
    end
    ready_prev = bus.ready;
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // S-box from its definition: multiplicative inverse (x^254) then affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h01;
      for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
      sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] v);
    return {sbox_t[v[31:24]], sbox_t[v[23:16]], sbox_t[v[15:8]], sbox_t[v[7:0]]};
  endfunction

  task automatic expand_key(input logic [255:0] key, input logic kl);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rc;
    int nk, nr;
    nk = kl ? 8 : 4;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk == 8 && i % nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++)
      rk_model[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
  endtask

  function automatic logic [127:0] ref_encrypt(input logic [127:0] pt, input int nr);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] v;
    v = pt ^ rk_model[0];
    for (int r = 1; r <= nr; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox_t[v[127 - 8*i -: 8]];
      for (int i = 0; i < 16; i++) t[i] = s[(i % 4) + 4*(((i / 4) + (i % 4)) % 4)];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (r < nr) begin
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      for (int i = 0; i < 16; i++) v[127 - 8*i -: 8] = s[i];
      v ^= rk_model[r];
    end
    return v;
  endfunction

  task automatic load_keys();
    for (int r = 0; r < 16; r++) rk_mem[r] = rk_model[r];
  endtask

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s got %h required %h", name, got, req);
    end
  endtask

  task automatic start_op(input logic [127:0] pt, input logic kl, input logic [127:0] ct,
                          input bit push, output int unsigned e0);
    exp_t item;
    @(negedge clk);
    bus.block  = pt;
    bus.keylen = kl;
    bus.next   = 1'b1;
    @(posedge clk);
    #1;
    e0 = cyc;
    bus.next = 1'b0;
    if (push) begin
      item.ct  = ct;
      item.due = e0 + (kl ? LAT256 : LAT128);
      sbq.push_back(item);
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 400 && sbq.size() != 0; i++) @(negedge clk);
    tests++;
    if (sbq.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout got %0d pending results, required 0", sbq.size());
      sbq.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got no completion, required finish before 200000 ns");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned e0;
    logic [127:0] pt1, pt2, ct1, ct2, m;
    logic [255:0] key;
    logic kl;

    build_sbox();
    for (int r = 0; r < 16; r++) rk_mem[r] = '0;
    bus.next = 1'b0; bus.keylen = 1'b0; bus.block = '0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ready", 128'(bus.ready), 128'd1);
    check("reset_round", 128'(bus.round), 128'd0);
    check("reset_new_block", bus.new_block, 128'h0);
    reset_n = 1'b1;

    // FIPS-197 C.1 and C.3
    expand_key(KEY_C1, 1'b0); load_keys();
    m = ref_encrypt(PT_C, 10);
    check("model_c1", m, CT_C1);
    start_op(PT_C, 1'b0, CT_C1, 1'b1, e0);
    wait_drain();
    expand_key(KEY_C3, 1'b1); load_keys();
    m = ref_encrypt(PT_C, 14);
    check("model_c3", m, CT_C3);
    start_op(PT_C, 1'b1, CT_C3, 1'b1, e0);
    wait_drain();

    // next pulsed mid-operation is ignored; result holds in IDLE afterwards
    expand_key(KEY_C1, 1'b0); load_keys();
    start_op(PT_C, 1'b0, CT_C1, 1'b1, e0);
    repeat (9) @(posedge clk);
    @(negedge clk); bus.next = 1'b1;
    @(posedge clk); #1 bus.next = 1'b0;
    wait_drain();
    repeat (LAT256 + 10) @(negedge clk);
    check("hold_ready", 128'(bus.ready), 128'd1);
    check("hold_new_block", bus.new_block, CT_C1);

    // reset mid-operation, then cold rerun
    start_op(PT_C, 1'b0, CT_C1, 1'b0, e0);
    repeat (RST_AT - 1) @(posedge clk);
    @(posedge clk); #2 reset_n = 1'b0;
    #3;
    check("abort_ready", 128'(bus.ready), 128'd1);
    check("abort_round", 128'(bus.round), 128'd0);
    check("abort_new_block", bus.new_block, 128'h0);
    @(negedge clk); reset_n = 1'b1;
    start_op(PT_C, 1'b0, CT_C1, 1'b1, e0);
    wait_drain();

    // next held high: two back-to-back operations, one IDLE cycle apart
    pt1 = {$urandom, $urandom, $urandom, $urandom};
    pt2 = {$urandom, $urandom, $urandom, $urandom};
    ct1 = ref_encrypt(pt1, 10);
    ct2 = ref_encrypt(pt2, 10);
    @(negedge clk);
    bus.block = pt1; bus.keylen = 1'b0; bus.next = 1'b1;
    @(posedge clk); #1;
    e0 = cyc;
    sbq.push_back('{ct: ct1, due: e0 + LAT128});
    sbq.push_back('{ct: ct2, due: e0 + 2*LAT128 + 1});
    repeat (2) @(posedge clk);
    #1 bus.block = pt2;
    repeat (LAT128 - 1) @(posedge clk);
    #1 bus.next = 1'b0;
    wait_drain();

    // keylen changed after E0 does not alter the round count
    start_op(PT_C, 1'b0, CT_C1, 1'b1, e0);
    bus.keylen = 1'b1;
    wait_drain();
    bus.keylen = 1'b0;

    // randomized keys, key lengths and plaintexts
    for (int n = 0; n < 6; n++) begin
      key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      kl  = 1'($urandom_range(0, 1));
      pt1 = {$urandom, $urandom, $urandom, $urandom};
      expand_key(key, kl); load_keys();
      ct1 = ref_encrypt(pt1, kl ? 14 : 10);
      start_op(pt1, kl, ct1, 1'b1, e0);
      wait_drain();
    end

    repeat (5) @(negedge clk);
    tests++;
    if (sbq.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_empty got %0d pending, required 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/aes_encryption.md
AES_ENCRYPTION -- requirements
Module: aes_encryption

Interface
REQ-001 Parameters: none; the only build-time option is the macro in Configuration.
REQ-002 Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- next  in  1  start-encryption request; sampled only in IDLE.
- keylen  in  1  key length: 0 = AES-128 (10 rounds), 1 = AES-256 (14 rounds).
- round  out  4  current round index, used by the key memory to select round_key.
- round_key  in  128  round key for the index on round, combinational from the key memory.
- block  in  128  plaintext block.
- new_block  out  128  ciphertext block, i.e. the state register {w0,w1,w2,w3}.
- ready  out  1  high when idle and the result is valid.

Function
REQ-003 The state SHALL be held as four 32-bit word registers w0..w3, with w0 = bits 127:96.
REQ-004 The FSM SHALL have the states IDLE, INIT, SBOX and MAIN.
REQ-005 IDLE with next=1: round := 0, ready := 0, keylen latched, go to INIT. next is ignored in every other state.
REQ-006 INIT: state := block XOR round_key (round 0); sword counter := 0; round := 1; go to SBOX.
REQ-007 SBOX: substitute the word selected by the sword counter through one forward aes_sbox (32-bit) instance; only that word is written; counter +1; when counter = 3, go to MAIN.
REQ-008 MAIN with round < Nr (Nr = 10 or 14, taken from the latched keylen):
- state := AddRoundKey(MixColumns(ShiftRows(state)), round_key);
- round +1; go to SBOX.
REQ-009 MAIN with round = Nr: state := AddRoundKey(ShiftRows(state), round_key); ready := 1; go to IDLE; round holds at Nr.
REQ-010 ShiftRows SHALL rotate row r of the column-major state left by r bytes.
REQ-011 MixColumns SHALL use the FIPS-197 matrix {02,03,01,01} with GF(2^8) reduction polynomial 0x11B.
REQ-012 Latency, counted from the rising edge that samples next (E0):
- ready rises at E51 for AES-128 and at E71 for AES-256;
- new_block is valid from that same edge.
REQ-013 block SHALL be stable from next assertion through edge E1; round_key SHALL be valid within the cycle that round presents its index.
REQ-014 new_block SHALL hold its value in IDLE until the next INIT.
REQ-015 next held high continuously SHALL start back-to-back operations, with exactly one IDLE cycle between operations.

Reset
REQ-016 reset_n low SHALL asynchronously force:
- state IDLE;
- ready = 1;
- round = 0;
- w0..w3 = 0;
- sword counter = 0;
- latched keylen = 0.
REQ-017 Assertion mid-operation SHALL abort the operation with no partial result retained; the first operation after deassertion SHALL behave as from cold reset.

Configuration
REQ-018 Macro AES_ENC_PARALLEL_SBOX_EN.
REQ-019 When the macro is defined:
- four aes_sbox instances are built;
- SBOX lasts one cycle and substitutes all four words;
- the sword counter is removed;
- ready rises at E21 for AES-128 and at E29 for AES-256.
REQ-020 When the macro is undefined: a single aes_sbox instance, with behaviour as in REQ-007 and REQ-012.
REQ-021 Ciphertext SHALL be bit-identical in both builds.

Verification
REQ-022 AES-128 FIPS-197 C.1: key 000102..0f, pt 00112233445566778899aabbccddeeff -> new_block 69c4e0d86a7b0430d8cdb78070b4c55a, ready rising at E51 (E21 with the macro).
REQ-023 AES-256 FIPS-197 C.3: key 000102..1f, same pt -> 8ea2b7ca516745bfeafc49904b496089, ready rising at E71 (E29 with the macro).
REQ-024 Pulse next at E10 of a running AES-128 operation -> ignored; the result is unchanged; exactly one result is produced.
REQ-025 Assert reset_n low at E30, then release and rerun C.1 -> after reset ready = 1, round = 0, new_block = 0; the rerun gives the correct ciphertext.
REQ-026 Hold next = 1 across two operations with different pt -> two correct results; the second starts one IDLE cycle after the first ready.
REQ-027 Toggle keylen after E0 mid-operation -> the round count follows the latched value (10 rounds).
